interrupt_controller_v2: RTL and testbench



---
 rtl/intc_pkg.sv | 23 ++
 rtl/intc_timer.sv | 42 ++++
 rtl/interrupt_controller_v2.sv | 201 ++++++++++++++++++++
 tb/tb_interrupt_controller_v2.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared definitions for interrupt_controller_v2: register offsets, FSM states
// and the spurious vector value.
package intc_pkg;

  localparam int ID_W = 4;

  localparam logic [2:0] OFF_VECTOR  = 3'd0;
  localparam logic [2:0] OFF_PENDING = 3'd1;
  localparam logic [2:0] OFF_MASK    = 3'd2;
  localparam logic [2:0] OFF_EDGE    = 3'd3;
  localparam logic [2:0] OFF_TLO     = 3'd4;
  localparam logic [2:0] OFF_THI     = 3'd5;
  localparam logic [2:0] OFF_TCTRL   = 3'd6;

  localparam logic [15:0] SPURIOUS_VEC = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

endpackage

// File: rtl/intc_timer.sv
// Free-running timer source: counts while run_i is set, wraps to 0 after TIMER_MAX
// with a one-cycle tick, and latches the upper half on a low-half read.
module intc_timer #(
  parameter int          TIMER_W   = 32,
  parameter logic [31:0] TIMER_MAX = 32'h100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_i,
  input  logic        lo_rd_i,
  output logic        tick_o,
  output logic [15:0] lo_o,
  output logic [15:0] hi_o
);

  localparam logic [TIMER_W-1:0] MAXV = TIMER_MAX[TIMER_W-1:0];

  logic [TIMER_W-1:0]  cnt_q, cnt_d;
  logic [TIMER_W-17:0] shadow_q, shadow_d;

  assign tick_o = run_i && (cnt_q == MAXV);

  always_comb begin
    cnt_d = cnt_q;
    if (run_i) cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    shadow_d = lo_rd_i ? cnt_q[TIMER_W-1:16] : shadow_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign lo_o = cnt_q[15:0];
  assign hi_o = 16'(shadow_q);

endmodule

// File: rtl/interrupt_controller_v2.sv
// Vectored interrupt controller: N_IRQ external lines plus one timer source (highest priority).
// Optional macro IRQ_SYNC_EN adds 2-flop synchronisers on b_irq_n, int_ack_n and nmi_n.
module interrupt_controller_v2
  import intc_pkg::*;
#(
  parameter int                N_IRQ     = 8,
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 14'h2000,
  parameter int                TIMER_W   = 32,
  parameter logic [31:0]       TIMER_MAX = 32'h100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_bus,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [15:0]       wr_data,
  output logic [15:0]       rd_data,
  input  logic [N_IRQ-1:0]  b_irq_n,
  input  logic              nmi_n,
  output logic              b_nmi_n,
  output logic              int_n,
  input  logic              int_ack_n
);

  localparam int NS = N_IRQ + 1;

  logic [N_IRQ-1:0] irq_n;
  logic             ack_n, nmi_s;

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] irq_s1_q, irq_s2_q;
  logic [1:0]       ack_s_q, nmi_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_s1_q <= '1;
      irq_s2_q <= '1;
      ack_s_q  <= '1;
      nmi_s_q  <= '1;
    end else begin
      irq_s1_q <= b_irq_n;
      irq_s2_q <= irq_s1_q;
      ack_s_q  <= {ack_s_q[0], int_ack_n};
      nmi_s_q  <= {nmi_s_q[0], nmi_n};
    end
  end

  assign irq_n = irq_s2_q;
  assign ack_n = ack_s_q[1];
  assign nmi_s = nmi_s_q[1];
`else
  assign irq_n = b_irq_n;
  assign ack_n = int_ack_n;
  assign nmi_s = nmi_n;
`endif

  state_e            state_q, state_d;
  logic [NS-1:0]     pend_q, pend_d, set_v, clr_v;
  logic [15:0]       mask_q;
  logic [N_IRQ-1:0]  edge_q, irq_prev_q;
  logic              run_q;
  logic              isv_valid_q;
  logic [ID_W-1:0]   isv_id_q;
  logic [15:0]       rd_data_q, rd_data_d, rd_val;
  logic              b_nmi_n_q;

  logic [ADDR_W-1:0] off;
  logic [2:0]        reg_sel;
  logic              hit, wr_en, rd_en, eoi, ack;
  logic              cand_valid, grant, spurious, tick;
  logic [ID_W-1:0]   cand_id;
  logic [NS-1:0]     edge_all;
  logic [15:0]       tim_lo, tim_hi;

  assign off      = addr_bus - BASE_ADDR;
  assign hit      = (off < ADDR_W'(7));
  assign reg_sel  = off[2:0];
  assign wr_en    = ~write_n & hit;
  assign rd_en    = ~read_n & write_n & hit;
  assign eoi      = wr_en && (reg_sel == OFF_VECTOR);
  assign ack      = ~ack_n;
  assign edge_all = {1'b1, edge_q};

  intc_timer #(
    .TIMER_W   (TIMER_W),
    .TIMER_MAX (TIMER_MAX)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run_i   (run_q),
    .lo_rd_i (rd_en && (reg_sel == OFF_TLO)),
    .tick_o  (tick),
    .lo_o    (tim_lo),
    .hi_o    (tim_hi)
  );

  // Ascending scan so the highest unmasked pending index (timer last) wins.
  always_comb begin
    cand_valid = 1'b0;
    cand_id    = '0;
    for (int i = 0; i < NS; i++) begin
      if (pend_q[i] && !mask_q[i]) begin
        cand_valid = 1'b1;
        cand_id    = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cand_valid) state_d = REQ;
      REQ:     if (!cand_valid) state_d = IDLE;
               else if (ack)    state_d = SERVICE;
      SERVICE: if (eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    int_n    = (state_q != REQ);
    grant    = (state_q == REQ) && cand_valid && ack;
    spurious = ack && !grant;
  end

  // A new edge in the same cycle as a clear takes precedence over the clear.
  always_comb begin
    set_v = '0;
    for (int i = 0; i < N_IRQ; i++) set_v[i] = edge_q[i] & irq_prev_q[i] & ~irq_n[i];
    set_v[N_IRQ] = tick;
    clr_v = '0;
    if (wr_en && (reg_sel == OFF_PENDING)) clr_v = wr_data[NS-1:0] & edge_all;
    for (int i = 0; i < NS; i++) begin
      if (grant && edge_all[i] && (cand_id == ID_W'(i))) clr_v[i] = 1'b1;
    end
    pend_d = (pend_q & ~clr_v) | set_v;
    for (int i = 0; i < N_IRQ; i++) begin
      if (!edge_q[i]) pend_d[i] = ~irq_n[i];
    end
  end

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      OFF_VECTOR:  rd_val = isv_valid_q ? 16'(isv_id_q) : SPURIOUS_VEC;
      OFF_PENDING: rd_val = 16'(pend_q);
      OFF_MASK:    rd_val = mask_q;
      OFF_EDGE:    rd_val = 16'(edge_q);
      OFF_TLO:     rd_val = tim_lo;
      OFF_THI:     rd_val = tim_hi;
      OFF_TCTRL:   rd_val = {15'd0, run_q};
      default:     rd_val = '0;
    endcase
    if (grant)         rd_data_d = 16'(cand_id);
    else if (spurious) rd_data_d = SPURIOUS_VEC;
    else if (rd_en)    rd_data_d = rd_val;
    else               rd_data_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      mask_q      <= '1;
      edge_q      <= '0;
      run_q       <= 1'b0;
      irq_prev_q  <= '1;
      isv_valid_q <= 1'b0;
      isv_id_q    <= '0;
      rd_data_q   <= '0;
      b_nmi_n_q   <= 1'b1;
    end else begin
      pend_q     <= pend_d;
      irq_prev_q <= irq_n;
      rd_data_q  <= rd_data_d;
      b_nmi_n_q  <= nmi_s;
      if (eoi) isv_valid_q <= 1'b0;
      if (grant) begin
        isv_valid_q <= 1'b1;
        isv_id_q    <= cand_id;
      end
      if (wr_en) begin
        case (reg_sel)
          OFF_MASK:  mask_q <= wr_data;
          OFF_EDGE:  edge_q <= wr_data[N_IRQ-1:0];
          OFF_TCTRL: run_q  <= wr_data[0];
          default: ;
        endcase
      end
    end
  end

  assign rd_data = rd_data_q;
  assign b_nmi_n = b_nmi_n_q;

endmodule

// File: tb/tb_interrupt_controller_v2.sv
// Self-checking bench for interrupt_controller_v2 (default build, TIMER_MAX=4):
// directed scenarios with literal expectations, then randomized traffic against a behavioural model.
module tb_interrupt_controller_v2;

  localparam int N    = 8;
  localparam int NS   = N + 1;
  localparam int TMAX = 4;
  localparam int BASE = 'h2000;
  localparam int S_IDLE = 0, S_REQ = 1, S_SVC = 2;

  logic        clk;
  logic        rst;
  logic [13:0] addr_bus;
  logic        read_n, write_n;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic [N-1:0] b_irq_n;
  logic        nmi_n, b_nmi_n, int_n, int_ack_n;

  interrupt_controller_v2 #(
    .N_IRQ     (N),
    .ADDR_W    (14),
    .BASE_ADDR (14'h2000),
    .TIMER_W   (32),
    .TIMER_MAX (32'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_bus  (addr_bus),
    .read_n    (read_n),
    .write_n   (write_n),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .b_irq_n   (b_irq_n),
    .nmi_n     (nmi_n),
    .b_nmi_n   (b_nmi_n),
    .int_n     (int_n),
    .int_ack_n (int_ack_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state (spec-level view of the controller).
  bit [15:0]   m_pend, m_mask, m_edge, m_shadow, m_rd;
  bit          m_run, m_nmi;
  int unsigned m_timer;
  int          m_state, m_isv;
  bit [N-1:0]  m_prev;

  function automatic int m_cand();
    int c = -1;
    for (int i = 0; i < NS; i++) if (m_pend[i] && !m_mask[i]) c = i;
    return c;
  endfunction

  function automatic bit [15:0] m_reg(input int o);
    case (o)
      0: return (m_isv < 0) ? 16'hFFFF : 16'(m_isv);
      1: return m_pend;
      2: return m_mask;
      3: return m_edge;
      4: return 16'(m_timer & 32'hFFFF);
      5: return m_shadow;
      6: return {15'd0, m_run};
      default: return 16'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    int o, cand;
    bit ok, wr, rd, ack, grant, tick;
    bit [15:0] np;
    if (rst) begin
      m_pend = 0; m_mask = 16'hFFFF; m_edge = 0; m_run = 0; m_timer = 0; m_shadow = 0;
      m_state = S_IDLE; m_isv = -1; m_rd = 0; m_nmi = 1; m_prev = '1;
    end else begin
      o     = int'(addr_bus) - BASE;
      ok    = (o >= 0) && (o <= 6);
      wr    = !write_n && ok;
      rd    = !read_n && write_n && ok;
      ack   = !int_ack_n;
      cand  = m_cand();
      grant = (m_state == S_REQ) && (cand >= 0) && ack;
      tick  = m_run && (m_timer == TMAX);
      if (grant)    m_rd = 16'(cand);
      else if (ack) m_rd = 16'hFFFF;
      else if (rd)  m_rd = m_reg(o);
      else          m_rd = 0;
      if (rd && o == 4) m_shadow = 16'(m_timer >> 16);
      np = m_pend;
      for (int i = 0; i < NS; i++) begin
        if (i < N && !m_edge[i]) np[i] = !b_irq_n[i];
        else begin
          if (wr && o == 1 && wr_data[i]) np[i] = 0;
          if (grant && cand == i) np[i] = 0;
          if (i < N && m_prev[i] && !b_irq_n[i]) np[i] = 1;
          if (i == N && tick) np[i] = 1;
        end
      end
      case (m_state)
        S_IDLE:  if (cand >= 0) m_state = S_REQ;
        S_REQ:   if (cand < 0) m_state = S_IDLE; else if (ack) m_state = S_SVC;
        default: if (wr && o == 0) m_state = S_IDLE;
      endcase
      if (wr && o == 0) m_isv = -1;
      if (grant) m_isv = cand;
      if (m_run) m_timer = tick ? 0 : m_timer + 1;
      if (wr && o == 2) m_mask = wr_data;
      if (wr && o == 3) m_edge = wr_data & 16'((1 << N) - 1);
      if (wr && o == 6) m_run = wr_data[0];
      m_prev = b_irq_n;
      m_nmi  = nmi_n;
      m_pend = np;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_rd_data", rd_data, m_rd);
      check("cyc_int_n", {15'd0, int_n}, {15'd0, m_state != S_REQ});
      check("cyc_b_nmi_n", {15'd0, b_nmi_n}, {15'd0, m_nmi});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wrreg(input int o, input logic [15:0] d);
    addr_bus = 14'(BASE + o); wr_data = d; write_n = 1'b0;
    @(negedge clk);
    write_n = 1'b1;
  endtask

  task automatic rdreg(input int o, output logic [15:0] v);
    addr_bus = 14'(BASE + o); read_n = 1'b0;
    @(negedge clk);
    read_n = 1'b1;
    v = rd_data;
  endtask

  task automatic do_ack(output logic [15:0] v);
    int_ack_n = 1'b0;
    @(negedge clk);
    int_ack_n = 1'b1;
    v = rd_data;
  endtask

  initial begin
    logic [15:0] v;
    int r, o, idx;
    rst = 1'b1; addr_bus = '0; read_n = 1'b1; write_n = 1'b1; wr_data = '0;
    b_irq_n = '1; nmi_n = 1'b1; int_ack_n = 1'b1;
    cyc(2);
    chk_en = 1'b1;
    check("rst_int_n", {15'd0, int_n}, 16'h1);
    check("rst_rd_data", rd_data, 16'h0);
    check("rst_b_nmi_n", {15'd0, b_nmi_n}, 16'h1);
    rst = 1'b0;
    rdreg(2, v); check("rst_mask", v, 16'hFFFF);
    rdreg(0, v); check("rst_vector", v, 16'hFFFF);

    // Level request on line 3, ack, EOI with the level still asserted
    wrreg(2, 16'h0); wrreg(3, 16'h0);
    b_irq_n[3] = 1'b0;
    cyc(1); check("t1_int_n_early", {15'd0, int_n}, 16'h1);
    cyc(1); check("t1_int_n_low", {15'd0, int_n}, 16'h0);
    do_ack(v); check("t1_vector", v, 16'd3);
    check("t1_int_n_svc", {15'd0, int_n}, 16'h1);
    wrreg(0, 16'h0); cyc(1); check("t1_reassert", {15'd0, int_n}, 16'h0);
    b_irq_n[3] = 1'b1; cyc(3);

    // Priority between lines 2 and 6
    b_irq_n[2] = 1'b0; b_irq_n[6] = 1'b0; cyc(2);
    do_ack(v); check("t2_vec6", v, 16'd6);
    b_irq_n[6] = 1'b1; wrreg(0, 16'h0); cyc(2);
    do_ack(v); check("t2_vec2", v, 16'd2);
    wrreg(0, 16'h0); b_irq_n[2] = 1'b1; cyc(3);

    // Edge mode on line 5; new edge beats a simultaneous W1C
    wrreg(3, 16'h0020);
    b_irq_n[5] = 1'b0; cyc(1); b_irq_n[5] = 1'b1; cyc(1);
    rdreg(1, v); check("t3_pend_set", v, 16'h0020);
    b_irq_n[5] = 1'b0; wrreg(1, 16'h0020); b_irq_n[5] = 1'b1;
    rdreg(1, v); check("t3_edge_beats_clr", v, 16'h0020);
    wrreg(1, 16'h0020);
    rdreg(1, v); check("t3_pend_clr", v, 16'h0000);
    check("t3_idle", {15'd0, int_n}, 16'h1);
    wrreg(3, 16'h0);

    // Timer source wraps at 4 and requests with top priority
    wrreg(6, 16'h1); cyc(5);
    rdreg(4, v); check("t4_timer_wrap", v, 16'h0);
    check("t4_int_n", {15'd0, int_n}, 16'h0);
    do_ack(v); check("t4_vector", v, 16'd8);
    wrreg(6, 16'h0); wrreg(0, 16'h0);
    rdreg(4, v); check("t4_lo_stopped", v, 16'd3);
    rdreg(5, v); check("t4_hi", v, 16'h0);

    // Spurious ack, then masking the requester while in REQ
    do_ack(v); check("t5_spurious", v, 16'hFFFF);
    check("t5_int_n", {15'd0, int_n}, 16'h1);
    b_irq_n[1] = 1'b0; cyc(2); check("t5_req", {15'd0, int_n}, 16'h0);
    wrreg(2, 16'h0002); cyc(1); check("t5_masked", {15'd0, int_n}, 16'h1);

    // Reset during SERVICE
    wrreg(2, 16'h0); cyc(2);
    do_ack(v); check("t6_vector", v, 16'd1);
    rst = 1'b1; cyc(1);
    check("t6_int_n", {15'd0, int_n}, 16'h1);
    check("t6_rd_data", rd_data, 16'h0);
    rst = 1'b0; b_irq_n[1] = 1'b1;
    rdreg(2, v); check("t6_mask", v, 16'hFFFF);
    rdreg(0, v); check("t6_vector_none", v, 16'hFFFF);

    // Randomized traffic, checked every cycle against the model
    for (int c = 0; c < 4000; c++) begin
      read_n = 1'b1; write_n = 1'b1; int_ack_n = 1'b1;
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, N - 1);
        b_irq_n[idx] = ~b_irq_n[idx];
      end
      nmi_n = ($urandom_range(0, 15) != 0);
      r = $urandom_range(0, 9);
      o = $urandom_range(0, 8);
      addr_bus = (o == 8) ? 14'h1FFF : 14'(BASE + o);
      if (r < 3) begin
        read_n = 1'b0;
        if ($urandom_range(0, 7) == 0) begin write_n = 1'b0; wr_data = 16'($urandom); end
      end else if (r < 5) begin
        write_n = 1'b0;
        wr_data = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom);
      end else if (r < 7 && !(m_state == S_REQ && m_cand() < 0)) begin
        int_ack_n = 1'b0;
      end
      @(negedge clk);
    end
    rst = 1'b0; read_n = 1'b1; write_n = 1'b1; int_ack_n = 1'b1;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
